dmem_arbiter: RTL and testbench

//  Shares the single data_mem port between two requesters: port 0 = core load/store path,

---
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_mem port between the core load/store
// path (port 0) and the debug/loader master (port 1). One transaction in
// flight at a time; the arbiter owns the memory enables and returns a single
// response pulse to whichever port issued the command.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 0,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [2:0]        req0_func3,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [2:0]        req1_func3,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Wait counter preload: WAIT runs RD_LAT-1 extra cycles after the first one.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be in the range 0..3");
  end

  logic [1:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic gnt_vld;
  logic gnt_port;
  logic idle;
  logic hs;

  assign idle = (state_q == S_IDLE);

  // Winner selection: fixed priority favours port 0; round-robin alternates on ties.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    if (PRIO_MODE != 0) begin
      gnt_port = ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      gnt_port = ~rr_last_q;
    end else begin
      gnt_port = ~req0_valid;
    end
  end

  // Ready only for the winner, only in IDLE, and never while reset is asserted.
  always_comb begin
    req0_ready = rst & idle & gnt_vld & ~gnt_port;
    req1_ready = rst & idle & gnt_vld & gnt_port;
    hs         = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  end

  // Transaction sequencing and command/response capture.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    func3_d   = func3_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          owner_d   = gnt_port;
          rr_last_d = gnt_port;
          we_d      = gnt_port ? req1_we    : req0_we;
          addr_d    = gnt_port ? req1_addr  : req0_addr;
          wdata_d   = gnt_port ? req1_wdata : req0_wdata;
          func3_d   = gnt_port ? req1_func3 : req0_func3;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          rdata_d = '0;
          state_d = S_RESP;
        end else if (RD_LAT == 0) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      func3_q   <= func3_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory and response drive; address/func3 stay stable while a read is pending.
  always_comb begin
    mem_rd_en  = (state_q == S_ISSUE) & ~we_q;
    mem_wr_en  = (state_q == S_ISSUE) & we_q;
    mem_addr   = (state_q == S_ISSUE || state_q == S_WAIT) ? addr_q  : '0;
    mem_func3  = (state_q == S_ISSUE || state_q == S_WAIT) ? func3_q : '0;
    mem_wdata  = (state_q == S_ISSUE) ? wdata_q : '0;
    rsp0_valid = (state_q == S_RESP) & ~owner_q;
    rsp1_valid = (state_q == S_RESP) & owner_q;
    rsp0_rdata = rsp0_valid ? rdata_q : '0;
    rsp1_rdata = rsp1_valid ? rdata_q : '0;
    busy       = ~idle;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Three instances share one stimulus:
//   u[0]: RD_LAT=0 round-robin, u[1]: RD_LAT=2 round-robin, u[2]: RD_LAT=3 fixed.
// Each instance has its own small data_mem model with matching read latency.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [2:0]  req0_func3, req1_func3;

  logic [2:0]  req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [2:0]  mem_rd_en, mem_wr_en, busy;
  logic [31:0] rsp0_rdata [3];
  logic [31:0] rsp1_rdata [3];
  logic [31:0] mem_addr   [3];
  logic [31:0] mem_wdata  [3];
  logic [2:0]  mem_func3  [3];
  logic [31:0] mem_rdata  [3];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    localparam int P = (g == 2) ? 1 : 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(L), .PRIO_MODE(P)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_func3 (req0_func3),
      .req0_ready (req0_ready[g]),
      .req1_valid (req1_valid),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_func3 (req1_func3),
      .req1_ready (req1_ready[g]),
      .rsp0_valid (rsp0_valid[g]),
      .rsp0_rdata (rsp0_rdata[g]),
      .rsp1_valid (rsp1_valid[g]),
      .rsp1_rdata (rsp1_rdata[g]),
      .mem_rd_en  (mem_rd_en[g]),
      .mem_wr_en  (mem_wr_en[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_func3  (mem_func3[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );

    // Memory model: data appears L cycles after the rd_en cycle, 0 otherwise.
    logic [31:0] mem [16];
    logic [3:0]  pa  [4];
    logic        pv  [4];
    logic [31:0] rdata;

    always @(posedge clk) begin
      if (mem_wr_en[g]) mem[mem_addr[g][5:2]] <= mem_wdata[g];
      pv[0] <= 1'b0;
      pa[0] <= 4'd0;
      pv[1] <= mem_rd_en[g];
      pa[1] <= mem_addr[g][5:2];
      for (int k = 2; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end

    always_comb begin
      rdata = '0;
      if (L == 0) begin
        if (mem_rd_en[g]) rdata = mem[mem_addr[g][5:2]];
      end else begin
        if (pv[L]) rdata = mem[pa[L]];
      end
    end

    assign mem_rdata[g] = rdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a store pending on port 0.
    rst        = 1'b0;
    req0_valid = 1'b1;
    req0_we    = 1'b1;
    req0_addr  = 32'h10;
    req0_wdata = 32'hDEADBEEF;
    req0_func3 = 3'd2;
    req1_valid = 1'b0;
    req1_we    = 1'b0;
    req1_addr  = 32'h0;
    req1_wdata = 32'h0;
    req1_func3 = 3'd0;
    cyc();
    cyc();
    #1;
    chk("rst_ready0", {29'd0, req0_ready}, 32'd0);
    chk("rst_busy", {29'd0, busy}, 32'd0);
    chk("rst_mem_en", {26'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_rsp", {26'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'd0);

    // Release: store on port 0 is accepted in this cycle T.
    rst = 1'b1;
    #1;
    chk("rel_ready0", {29'd0, req0_ready}, 32'd7);
    chk("rel_ready1", {29'd0, req1_ready}, 32'd0);
    cyc();
    // T+1: requester changes its inputs; latched command must not follow.
    req0_valid = 1'b0;
    req0_addr  = 32'h99;
    req0_wdata = 32'h1234;
    req0_func3 = 3'd5;
    #1;
    chk("st_wr_en", {29'd0, mem_wr_en}, 32'd7);
    chk("st_rd_en", {29'd0, mem_rd_en}, 32'd0);
    chk("st_addr", mem_addr[0], 32'h10);
    chk("st_wdata", mem_wdata[0], 32'hDEADBEEF);
    chk("st_func3", {29'd0, mem_func3[0]}, 32'd2);
    chk("st_busy1", {29'd0, busy}, 32'd7);
    chk("st_rsp_early", {29'd0, rsp0_valid}, 32'd0);
    cyc();
    #1;
    chk("st_rsp0", {29'd0, rsp0_valid}, 32'd7);
    chk("st_rdata0", rsp0_rdata[0], 32'd0);
    chk("st_rsp1", {29'd0, rsp1_valid}, 32'd0);
    chk("st_busy2", {29'd0, busy}, 32'd7);
    chk("st_wr_off", {29'd0, mem_wr_en}, 32'd0);
    cyc();
    #1;
    chk("st_idle", {29'd0, busy}, 32'd0);
    chk("st_rsp_end", {29'd0, rsp0_valid}, 32'd0);

    // Load on port 1 from 0x10; latencies 0/2/3 across the instances.
    req1_valid = 1'b1;
    req1_we    = 1'b0;
    req1_addr  = 32'h10;
    req1_func3 = 3'd2;
    #1;
    chk("ld_ready1", {29'd0, req1_ready}, 32'd7);
    cyc();
    req1_valid = 1'b0;
    req1_addr  = 32'h44;
    #1;
    chk("ld_rd_en", {29'd0, mem_rd_en}, 32'd7);
    chk("ld_wr_en", {29'd0, mem_wr_en}, 32'd0);
    chk("ld_addr", mem_addr[1], 32'h10);
    cyc();
    #1;
    chk("ld_rd_off", {29'd0, mem_rd_en}, 32'd0);
    chk("ld_addr_held", mem_addr[1], 32'h10);
    chk("ld_busy_wait", {31'd0, busy[1]}, 32'd1);
    chk("ld_lat0_rsp", {31'd0, rsp1_valid[0]}, 32'd1);
    chk("ld_lat0_data", rsp1_rdata[0], 32'hDEADBEEF);
    chk("ld_lat2_early2", {31'd0, rsp1_valid[1]}, 32'd0);
    cyc();
    #1;
    chk("ld_lat2_early3", {31'd0, rsp1_valid[1]}, 32'd0);
    cyc();
    #1;
    chk("ld_lat2_rsp", {31'd0, rsp1_valid[1]}, 32'd1);
    chk("ld_lat2_data", rsp1_rdata[1], 32'hDEADBEEF);
    chk("ld_lat2_rsp0", {31'd0, rsp0_valid[1]}, 32'd0);
    chk("ld_lat3_early", {31'd0, rsp1_valid[2]}, 32'd0);
    cyc();
    #1;
    chk("ld_lat2_done", {31'd0, rsp1_valid[1]}, 32'd0);
    chk("ld_lat2_zero", rsp1_rdata[1], 32'd0);
    chk("ld_lat2_idle", {31'd0, busy[1]}, 32'd0);
    chk("ld_lat3_rsp", {31'd0, rsp1_valid[2]}, 32'd1);
    chk("ld_lat3_data", rsp1_rdata[2], 32'hDEADBEEF);
    cyc();

    // Re-enter reset so round-robin starts from its reset preference.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req0_valid = 1'b1;
    req0_we    = 1'b1;
    req0_addr  = 32'h20;
    req0_wdata = 32'hA0;
    req0_func3 = 3'd2;
    req1_valid = 1'b1;
    req1_we    = 1'b1;
    req1_addr  = 32'h24;
    req1_wdata = 32'hB1;
    req1_func3 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", {31'd0, req0_ready[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", {31'd0, req1_ready[0]}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("fx_ready0", {31'd0, req0_ready[2]}, 32'd1);
      chk("fx_ready1", {31'd0, req1_ready[2]}, 32'd0);
      cyc();
      #1;
      chk("rr_addr", mem_addr[0], (i % 2 == 0) ? 32'h20 : 32'h24);
      chk("fx_addr", mem_addr[2], 32'h20);
      cyc();
      #1;
      chk("rr_rsp0", {31'd0, rsp0_valid[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_rsp1", {31'd0, rsp1_valid[0]}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("fx_rsp0", {31'd0, rsp0_valid[2]}, 32'd1);
      cyc();
    end

    // Back-to-back stores on port 0 only: one handshake every 3 cycles.
    req1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req0_addr  = 32'h30;
      req0_wdata = 32'h100 + k;
      #1;
      chk("b2b_ready", {31'd0, req0_ready[0]}, 32'd1);
      cyc();
      #1;
      chk("b2b_ready_t1", {31'd0, req0_ready[0]}, 32'd0);
      chk("b2b_wr_en", {31'd0, mem_wr_en[0]}, 32'd1);
      chk("b2b_wdata", mem_wdata[0], 32'h100 + k);
      cyc();
      #1;
      chk("b2b_ready_t2", {31'd0, req0_ready[0]}, 32'd0);
      chk("b2b_ack", {31'd0, rsp0_valid[0]}, 32'd1);
      cyc();
    end

    // Reset in the middle of a 3-cycle read wait on u[2].
    req0_valid = 1'b0;
    cyc();
    req0_valid = 1'b1;
    req0_we    = 1'b0;
    req0_addr  = 32'h10;
    #1;
    chk("mw_ready", {31'd0, req0_ready[2]}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    #1;
    chk("mw_busy", {31'd0, busy[2]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mw_rst_busy", {29'd0, busy}, 32'd0);
    chk("mw_rst_addr", mem_addr[2], 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("mw_no_rsp", {31'd0, rsp0_valid[2]}, 32'd0);
      cyc();
    end
    req0_valid = 1'b1;
    #1;
    chk("mw_next_ready", {31'd0, req0_ready[2]}, 32'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    #1;
    chk("mw_next_rsp", {31'd0, rsp0_valid[2]}, 32'd1);
    chk("mw_next_data", rsp0_rdata[2], 32'hDEADBEEF);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
